// File: rtl/vga_stream_ctrl.sv
// VGA pixel stream controller.
// Sequences the pixel FIFO against the display timing: waits for the FIFO to
// fill, starts on a frame boundary, reads one word per active pixel, and on
// underflow drains the FIFO and asks the writer to restart at frame address 0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | stream disabled, no reads
// WAIT_FILL  | waiting for FIFO level to reach the start threshold
// WAIT_SOF   | FIFO primed, waiting for the last pixel of the frame
// RUN        | streaming: one FIFO read per active pixel
// FLUSH      | underflow seen: drain FIFO, hold resync_req until acked
module vga_stream_ctrl #(
   parameter int HDISP  = 640,
   parameter int VDISP  = 480,
   parameter int HTOTAL = 800,
   parameter int VTOTAL = 524
) (
   input  logic        VGA_CLK,
   input  logic        RST,
   input  logic        enable,
   input  logic [10:0] ctH,
   input  logic [9:0]  ctV,
   input  logic        fifo_rempty,
   input  logic        fifo_ralmost_full,
   input  logic        resync_ack,
   output logic        fifo_read,
   output logic        pix_valid,
   output logic        resync_req,
   output logic [7:0]  frame_cnt,
   output logic [15:0] underflow_cnt,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_FILL = 3'd1,
      ST_WAIT_SOF  = 3'd2,
      ST_RUN       = 3'd3,
      ST_FLUSH     = 3'd4
   } state_t;

   localparam logic [10:0] H_DISP = 11'(HDISP);
   localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
   localparam logic [9:0]  V_DISP = 10'(VDISP);
   localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);

   state_t      state_q;
   logic        pix_valid_q;
   logic        resync_req_q;
   logic        ack_seen_q;
   logic [7:0]  frame_cnt_q;
   logic [7:0]  frame_cnt_d;
   logic [15:0] underflow_cnt_q;
   logic [15:0] underflow_cnt_d;

   logic active;
   logic sof;
   logic underflow;

   assign active    = (ctH < H_DISP) && (ctV < V_DISP);
   assign sof       = (ctH == H_LAST) && (ctV == V_LAST);
   assign underflow = (state_q == ST_RUN) && active && fifo_rempty;

   // FIFO read strobe: active pixels in RUN, unconditional drain in FLUSH.
   // Gated by enable so nothing is popped on the cycle the stream is dropped.
   always_comb begin
      fifo_read = 1'b0;
      if (!RST && enable) begin
         case (state_q)
            ST_RUN:   fifo_read = active && !fifo_rempty;
            ST_FLUSH: fifo_read = !fifo_rempty;
            default:  fifo_read = 1'b0;
         endcase
      end
   end

   // Counter next values; frame count skips a frame boundary that coincides
   // with leaving RUN, underflow count saturates.
   always_comb begin
      frame_cnt_d     = frame_cnt_q;
      underflow_cnt_d = underflow_cnt_q;
      if (enable) begin
         if (sof && ((state_q == ST_WAIT_SOF) || ((state_q == ST_RUN) && !underflow)))
            frame_cnt_d = frame_cnt_q + 8'd1;
         if (underflow && (underflow_cnt_q != 16'hFFFF))
            underflow_cnt_d = underflow_cnt_q + 16'd1;
      end
   end

   // Sequencing FSM with registered outputs and counters.
   always_ff @(posedge VGA_CLK) begin
      if (RST) begin
         state_q         <= ST_IDLE;
         pix_valid_q     <= 1'b0;
         resync_req_q    <= 1'b0;
         ack_seen_q      <= 1'b0;
         frame_cnt_q     <= 8'd0;
         underflow_cnt_q <= 16'd0;
      end else begin
         pix_valid_q     <= (state_q == ST_RUN) && fifo_read;
         frame_cnt_q     <= frame_cnt_d;
         underflow_cnt_q <= underflow_cnt_d;
         if (!enable) begin
            state_q      <= ST_IDLE;
            resync_req_q <= 1'b0;
            ack_seen_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q <= ST_WAIT_FILL;
               end
               ST_WAIT_FILL: begin
                  if (fifo_ralmost_full)
                     state_q <= ST_WAIT_SOF;
               end
               ST_WAIT_SOF: begin
                  if (sof)
                     state_q <= ST_RUN;
               end
               ST_RUN: begin
                  if (underflow) begin
                     state_q      <= ST_FLUSH;
                     resync_req_q <= 1'b1;
                     ack_seen_q   <= 1'b0;
                  end
               end
               ST_FLUSH: begin
                  if (resync_ack) begin
                     resync_req_q <= 1'b0;
                     ack_seen_q   <= 1'b1;
                  end
                  // ack and empty may arrive in either order or together
                  if ((ack_seen_q || resync_ack) && fifo_rempty) begin
                     state_q      <= ST_WAIT_FILL;
                     resync_req_q <= 1'b0;
                     ack_seen_q   <= 1'b0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign pix_valid     = pix_valid_q;
   assign resync_req    = resync_req_q;
   assign frame_cnt     = frame_cnt_q;
   assign underflow_cnt = underflow_cnt_q;
   assign state         = state_q;

endmodule

// File: tb/tb_vga_stream_ctrl.sv
// Testbench for vga_stream_ctrl: directed stimulus pushes hand-computed
// expectations into a scoreboard queue; a negedge monitor pops and compares.
module tb_vga_stream_ctrl;

   localparam int S_STATE = 0;
   localparam int S_RD    = 1;
   localparam int S_PV    = 2;
   localparam int S_REQ   = 3;
   localparam int S_FCNT  = 4;
   localparam int S_UCNT  = 5;
   localparam int S_RDCNT = 6;
   localparam int S_PVCNT = 7;

   typedef struct {
      int          cyc;
      int          sig;
      logic [31:0] val;
      string       name;
   } chk_t;

   logic        VGA_CLK;
   logic        RST;
   logic        enable;
   logic [10:0] ctH;
   logic [9:0]  ctV;
   logic        fifo_rempty;
   logic        fifo_ralmost_full;
   logic        resync_ack;
   logic        fifo_read;
   logic        pix_valid;
   logic        resync_req;
   logic [7:0]  frame_cnt;
   logic [15:0] underflow_cnt;
   logic [2:0]  state;

   int   cyc    = 0;
   int   rd_cnt = 0;
   int   pv_cnt = 0;
   int   total  = 0;
   int   bad    = 0;
   chk_t sb[$];
   chk_t cur;
   logic [31:0] act;

   vga_stream_ctrl dut (
      .VGA_CLK           (VGA_CLK),
      .RST               (RST),
      .enable            (enable),
      .ctH               (ctH),
      .ctV               (ctV),
      .fifo_rempty       (fifo_rempty),
      .fifo_ralmost_full (fifo_ralmost_full),
      .resync_ack        (resync_ack),
      .fifo_read         (fifo_read),
      .pix_valid         (pix_valid),
      .resync_req        (resync_req),
      .frame_cnt         (frame_cnt),
      .underflow_cnt     (underflow_cnt),
      .state             (state)
   );

   initial VGA_CLK = 1'b0;
   always #5 VGA_CLK = ~VGA_CLK;

   always @(posedge VGA_CLK) cyc <= cyc + 1;

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_STATE: return 32'(state);
         S_RD:    return 32'(fifo_read);
         S_PV:    return 32'(pix_valid);
         S_REQ:   return 32'(resync_req);
         S_FCNT:  return 32'(frame_cnt);
         S_UCNT:  return 32'(underflow_cnt);
         S_RDCNT: return 32'(rd_cnt);
         S_PVCNT: return 32'(pv_cnt);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: accumulate read/valid counts, then compare due expectations.
   always @(negedge VGA_CLK) begin
      if (fifo_read === 1'b1) rd_cnt++;
      if (pix_valid === 1'b1) pv_cnt++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         cur = sb.pop_front();
         act = actual(cur.sig);
         total++;
         if (act !== cur.val) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", cur.name, cyc, act, cur.val);
         end
      end
   end

   task automatic tick(input int h, input int v);
      @(posedge VGA_CLK);
      #1;
      ctH = 11'(h);
      ctV = 10'(v);
   endtask

   task automatic chk(input int sig, input logic [31:0] val, input string name);
      chk_t c;
      c.cyc  = cyc;
      c.sig  = sig;
      c.val  = val;
      c.name = name;
      sb.push_back(c);
   endtask

   initial begin
      RST = 1'b1; enable = 1'b0; fifo_rempty = 1'b1;
      fifo_ralmost_full = 1'b0; resync_ack = 1'b0;
      ctH = '0; ctV = '0;

      // reset values
      tick(0, 0);
      tick(0, 0);
      chk(S_STATE, 0, "rst_state"); chk(S_RD, 0, "rst_rd"); chk(S_PV, 0, "rst_pv");
      chk(S_REQ, 0, "rst_req"); chk(S_FCNT, 0, "rst_fcnt"); chk(S_UCNT, 0, "rst_ucnt");

      // normal start
      tick(0, 100); RST = 1'b0; enable = 1'b1; fifo_rempty = 1'b0;
      chk(S_STATE, 0, "start_idle");
      for (int i = 1; i <= 9; i++) begin
         tick(i, 100);
         chk(S_STATE, 1, "wait_fill");
      end
      chk(S_RD, 0, "wait_fill_rd");
      tick(10, 100); fifo_ralmost_full = 1'b1;
      chk(S_STATE, 1, "fill_before_af");
      tick(11, 100);
      chk(S_STATE, 2, "wait_sof"); chk(S_RD, 0, "wait_sof_rd");
      tick(798, 523);
      tick(799, 523);
      chk(S_STATE, 2, "sof_still_wait"); chk(S_FCNT, 0, "sof_fcnt_pre");
      tick(0, 0);
      chk(S_STATE, 3, "run_at_00"); chk(S_FCNT, 1, "fcnt_first");
      chk(S_RD, 1, "run_rd_00"); chk(S_PV, 0, "run_pv_00");
      for (int h = 1; h < 800; h++) begin
         tick(h, 0);
         if (h == 1)   chk(S_PV, 1, "pv_lag");
         if (h == 640) begin chk(S_RD, 0, "rd_blank"); chk(S_PV, 1, "pv_last"); end
         if (h == 641) chk(S_PV, 0, "pv_blank");
      end
      chk(S_RDCNT, 640, "rd_line0"); chk(S_PVCNT, 640, "pv_line0");
      for (int h = 0; h < 800; h++) tick(h, 1);
      chk(S_RDCNT, 1280, "rd_line1"); chk(S_PVCNT, 1280, "pv_line1");
      for (int h = 0; h < 800; h++) tick(h, 479);
      chk(S_RDCNT, 1920, "rd_line479");
      tick(0, 480);
      chk(S_RD, 0, "rd_vblank"); chk(S_PV, 0, "pv_vblank");

      // enable drop mid-RUN
      tick(299, 10);
      chk(S_RD, 1, "pre_drop_rd");
      tick(300, 10); enable = 1'b0;
      chk(S_RD, 0, "drop_rd"); chk(S_STATE, 3, "drop_still_run");
      tick(301, 10);
      chk(S_STATE, 0, "drop_idle"); chk(S_RD, 0, "drop_idle_rd");
      chk(S_FCNT, 1, "drop_fcnt"); chk(S_PV, 0, "drop_pv");
      tick(302, 10); enable = 1'b1;
      chk(S_STATE, 0, "reen_idle");
      tick(303, 10);
      chk(S_STATE, 1, "reen_fill");
      tick(304, 10);
      chk(S_STATE, 2, "reen_sof");
      tick(799, 523);
      tick(0, 0);
      chk(S_STATE, 3, "reen_run"); chk(S_FCNT, 2, "reen_fcnt");

      // underflow at (100,5)
      tick(99, 5);
      chk(S_RD, 1, "pre_uf_rd");
      tick(100, 5); fifo_rempty = 1'b1;
      chk(S_RD, 0, "uf_rd"); chk(S_STATE, 3, "uf_still_run"); chk(S_PV, 1, "uf_pv_prev");
      tick(101, 5); fifo_rempty = 1'b0;
      chk(S_STATE, 4, "uf_flush"); chk(S_UCNT, 1, "uf_ucnt");
      chk(S_REQ, 1, "uf_req"); chk(S_PV, 0, "uf_pv"); chk(S_RD, 1, "flush_drain");
      for (int h = 102; h <= 120; h++) begin
         tick(h, 5);
         chk(S_PV, 0, "flush_pv");
      end
      tick(799, 523);
      tick(0, 0);
      chk(S_FCNT, 2, "flush_no_fcnt"); chk(S_STATE, 4, "flush_hold");

      // resync: ack before empty
      tick(5, 0); resync_ack = 1'b1;
      chk(S_REQ, 1, "ackfirst_req_hold"); chk(S_STATE, 4, "ackfirst_st");
      tick(6, 0); resync_ack = 1'b0;
      chk(S_REQ, 0, "ackfirst_req_drop"); chk(S_STATE, 4, "ackfirst_wait_empty");
      tick(7, 0); fifo_rempty = 1'b1;
      chk(S_STATE, 4, "ackfirst_st2"); chk(S_RD, 0, "flush_empty_rd");
      tick(8, 0);
      chk(S_STATE, 1, "ackfirst_done"); chk(S_REQ, 0, "ackfirst_req_end");
      tick(9, 0); fifo_rempty = 1'b0;
      chk(S_STATE, 2, "ackfirst_sof");
      tick(799, 523);
      tick(0, 0);
      chk(S_STATE, 3, "run3"); chk(S_FCNT, 3, "fcnt3");

      // resync: empty before ack
      tick(50, 2); fifo_rempty = 1'b1;
      tick(51, 2);
      chk(S_STATE, 4, "uf2_flush"); chk(S_UCNT, 2, "uf2_ucnt"); chk(S_REQ, 1, "uf2_req");
      tick(52, 2);
      chk(S_STATE, 4, "empfirst_wait_ack");
      tick(53, 2);
      chk(S_STATE, 4, "empfirst_wait_ack2"); chk(S_REQ, 1, "empfirst_req");
      tick(54, 2); resync_ack = 1'b1;
      chk(S_STATE, 4, "empfirst_ack_cyc");
      tick(55, 2); resync_ack = 1'b0; fifo_rempty = 1'b0;
      chk(S_STATE, 1, "empfirst_done"); chk(S_REQ, 0, "empfirst_req_drop");

      // enable=0 beats underflow
      tick(56, 2);
      chk(S_STATE, 2, "prio_sof");
      tick(799, 523);
      tick(0, 0);
      chk(S_STATE, 3, "prio_run"); chk(S_FCNT, 4, "fcnt4");
      tick(10, 3); fifo_rempty = 1'b1; enable = 1'b0;
      tick(11, 3); fifo_rempty = 1'b0; enable = 1'b1;
      chk(S_STATE, 0, "prio_idle"); chk(S_UCNT, 2, "prio_ucnt");

      // frame counter wrap from reset
      tick(0, 500); RST = 1'b1;
      tick(1, 500); RST = 1'b0;
      chk(S_FCNT, 0, "wrap_rst_fcnt"); chk(S_STATE, 0, "wrap_rst_state");
      tick(2, 500);
      tick(3, 500);
      chk(S_STATE, 2, "wrap_wait_sof");
      for (int k = 1; k <= 256; k++) begin
         tick(799, 523);
         tick(0, 500);
         if (k == 1)   chk(S_FCNT, 1, "wrap_1");
         if (k == 255) chk(S_FCNT, 255, "wrap_255");
         if (k == 256) chk(S_FCNT, 0, "wrap_0");
      end

      // underflow counter saturation
      tick(0, 500);
      force dut.underflow_cnt_q = 16'hFFFE;
      tick(1, 500);
      release dut.underflow_cnt_q;
      tick(100, 5); fifo_rempty = 1'b1;
      tick(101, 5);
      chk(S_UCNT, 32'hFFFF, "sat_reach"); chk(S_STATE, 4, "sat_flush1");
      resync_ack = 1'b1;
      tick(102, 5); resync_ack = 1'b0; fifo_rempty = 1'b0;
      chk(S_STATE, 1, "sat_refill");
      tick(103, 5);
      chk(S_STATE, 2, "sat_wait_sof");
      tick(799, 523);
      tick(0, 0);
      chk(S_STATE, 3, "sat_run");
      tick(100, 5); fifo_rempty = 1'b1;
      tick(101, 5); fifo_rempty = 1'b0;
      chk(S_STATE, 4, "sat_flush2"); chk(S_UCNT, 32'hFFFF, "sat_hold"); chk(S_REQ, 1, "sat_req");

      // reset during FLUSH with resync_req high
      tick(102, 5); RST = 1'b1;
      chk(S_RD, 0, "rstf_rd_forced"); chk(S_REQ, 1, "rstf_req_pre");
      tick(103, 5); RST = 1'b0;
      chk(S_STATE, 0, "rstf_state"); chk(S_REQ, 0, "rstf_req"); chk(S_PV, 0, "rstf_pv");
      chk(S_FCNT, 0, "rstf_fcnt"); chk(S_UCNT, 0, "rstf_ucnt"); chk(S_RD, 0, "rstf_rd");

      tick(0, 500);
      tick(0, 500);
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL sb_drain pending=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_stream_ctrl.md
VGA_STREAM_CTRL -- requirements
Module: vga_stream_ctrl

Interface
REQ-001 SHALL have parameter HDISP, default 640, active pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameter HTOTAL, default 800, pixel clocks per line.
REQ-004 SHALL have parameter VTOTAL, default 524, lines per frame.
REQ-005 SHALL have port VGA_CLK, input, 1 bit: pixel clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port enable, input, 1 bit: stream enable.
REQ-008 SHALL have port ctH, input, 11 bits: horizontal counter, 0..HTOTAL-1.
REQ-009 SHALL have port ctV, input, 10 bits: vertical counter, 0..VTOTAL-1.
REQ-010 SHALL have port fifo_rempty, input, 1 bit: pixel FIFO read-side empty.
REQ-011 SHALL have port fifo_ralmost_full, input, 1 bit: FIFO level at or above the start threshold.
REQ-012 SHALL have port resync_ack, input, 1 bit: writer has restarted at frame address 0; already synchronised to VGA_CLK.
REQ-013 SHALL have port fifo_read, output, 1 bit: FIFO read strobe; combinational.
REQ-014 SHALL have port pix_valid, output, 1 bit: registered; FIFO data valid for display this cycle, else display black.
REQ-015 SHALL have port resync_req, output, 1 bit: registered; request writer restart.
REQ-016 SHALL have port frame_cnt, output, 8 bits: frames started in RUN.
REQ-017 SHALL have port underflow_cnt, output, 16 bits: underflow events.
REQ-018 SHALL have port state, output, 3 bits: IDLE=0, WAIT_FILL=1, WAIT_SOF=2, RUN=3, FLUSH=4.

Function
REQ-019 SHALL define active = (ctH < HDISP) && (ctV < VDISP).
REQ-020 SHALL define sof = (ctH == HTOTAL-1) && (ctV == VTOTAL-1).
REQ-021 SHALL transition IDLE -> WAIT_FILL when enable=1.
REQ-022 SHALL transition WAIT_FILL -> WAIT_SOF when fifo_ralmost_full=1.
REQ-023 SHALL transition WAIT_SOF -> RUN on the cycle after sof=1, so RUN begins at ctH=0, ctV=0.
REQ-024 SHALL, in RUN, drive fifo_read = active && !fifo_rempty; pix_valid SHALL equal fifo_read delayed one cycle, matching the FIFO one-cycle read latency.
REQ-025 SHALL flag underflow in RUN when active=1 && fifo_rempty=1; the FSM SHALL go to FLUSH next cycle and underflow_cnt SHALL increment, saturating at 16'hFFFF.
REQ-026 SHALL increment frame_cnt on each sof while in WAIT_SOF or RUN (not when RUN is being left), wrapping from 255 to 0.
REQ-027 SHALL, on entry to FLUSH, set resync_req=1 and hold it until resync_ack is sampled high, then clear it on the next cycle.
REQ-028 SHALL, in FLUSH, drive fifo_read = !fifo_rempty (drain) with pix_valid held at 0.
REQ-029 SHALL latch "ack seen" in FLUSH and go FLUSH -> WAIT_FILL when ack seen && fifo_rempty=1; ack and empty may arrive in either order.
REQ-030 SHALL, when enable=0 in any state, go to IDLE next cycle, with fifo_read=0 in IDLE and resync_req and ack-seen cleared; counters SHALL be retained.
REQ-031 SHALL hold fifo_read=0 in IDLE, WAIT_FILL and WAIT_SOF; pix_valid SHALL be 0 one cycle after leaving RUN.
REQ-032 SHALL use priority enable=0 > underflow > sof for simultaneous events.

Reset
REQ-033 SHALL, while RST=1, force state=IDLE, pix_valid=0, resync_req=0, ack-seen=0, frame_cnt=0, underflow_cnt=0; fifo_read SHALL be 0.
REQ-034 SHALL, when RST asserts mid-RUN or mid-FLUSH, abort the frame with no counter update on that cycle.

Verification
REQ-035 SHALL cover normal start: enable=1, almost_full at cycle 10, FIFO never empty -> state 1->2, RUN at (0,0), fifo_read high exactly 640 cycles per active line, 307200 per frame, frame_cnt=1 after first sof.
REQ-036 SHALL cover underflow: force rempty at ctH=100, ctV=5 in RUN -> underflow_cnt=1, state=4 next cycle, resync_req=1, pix_valid=0 for the rest of the frame.
REQ-037 SHALL cover resync ordering: in FLUSH, ack before empty, and empty before ack -> both reach WAIT_FILL only when both are seen; resync_req drops one cycle after ack.
REQ-038 SHALL cover enable drop mid-RUN at ctH=300 -> IDLE next cycle, fifo_read=0, frame_cnt unchanged; re-enable restarts from WAIT_FILL.
REQ-039 SHALL cover wrap and saturation: 256 frames -> frame_cnt=0; underflow_cnt preloaded near 16'hFFFF stays at 16'hFFFF.
REQ-040 SHALL cover reset during FLUSH with resync_req=1 -> all outputs at reset values on the next cycle.
